serial_debug_arbiter: RTL and testbench
=======================================

SERIAL_DEBUG_ARBITER -- requirements
Module: serial_debug_arbiter

Interface
REQ-001 SHALL have parameter BITS, default 128, payload bits per frame; SF_BITS = BITS+16 (payload + 15 address bits + 1 direction bit).
REQ-002 SHALL have parameter TIMEOUT, default 65535, idle clk cycles allowed between return-clock rising edges before abort.
REQ-003 SHALL have port clk  input  1  single clock, all logic posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port prescaler  input  8  clk cycles per debug clock half-period; 0 treated as 1.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  requester N holds a frame for transmission.
REQ-007 SHALL have ports req0_frame/req1_frame  input  SF_BITS  outgoing frame, MSB first.
REQ-008 SHALL have ports req0_ready/req1_ready  output  1  one-cycle accept pulse.
REQ-009 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle response pulse.
REQ-010 SHALL have port rsp_frame  output  SF_BITS  returned frame, shared by both requesters.
REQ-011 SHALL have port rsp_timeout  output  1  response aborted by timeout.
REQ-012 SHALL have port busy  output  1  high from accept through response.
REQ-013 SHALL have ports debug_rx_data, debug_rx_clk  output  1 each  to first debug node.
REQ-014 SHALL have ports debug_tx_data, debug_tx_clk  input  1 each  from last debug node.

Function
REQ-015 SHALL use states IDLE, TX_LOW, TX_HIGH, RX_WAIT, RESP.
REQ-016 IDLE: if any reqN_valid, SHALL grant one, pulse its reqN_ready, capture reqN_frame into the shift register, latch grant index, enter TX_LOW; all in that cycle.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; after reset, req0 wins the first tie.
REQ-018 A request not granted SHALL keep its valid high; ready SHALL never pulse outside IDLE.
REQ-019 TX_LOW entry SHALL drive debug_rx_clk=0 and debug_rx_data=current MSB; hold for prescaler cycles, then TX_HIGH.
REQ-020 TX_HIGH SHALL drive debug_rx_clk=1 with data stable for prescaler cycles, then shift left; after SF_BITS high phases enter RX_WAIT, else TX_LOW.
REQ-021 Exactly SF_BITS falling/rising pairs SHALL be sent per frame; debug_rx_clk idles high.
REQ-022 debug_tx_data/debug_tx_clk SHALL pass a 2-flop synchronizer; a rising edge is detected from synced current vs previous clock.
REQ-023 Receiver SHALL be armed from the accept cycle (edges during TX are captured); each synced rising edge shifts synced data into the receive register LSB.
REQ-024 After SF_BITS received bits, SHALL enter RESP (from RX_WAIT, or upon TX completion if already complete).
REQ-025 Timeout counter SHALL clear at accept and on each received edge, increment otherwise in TX_*/RX_WAIT states; counting only in RX_WAIT reaching TIMEOUT SHALL enter RESP with rsp_timeout=1.
REQ-026 RESP SHALL load rsp_frame from the receive register (partial bits as shifted), set rsp_timeout, pulse rsp_valid of the granted index for one cycle, return to IDLE.
REQ-027 rsp_frame and rsp_timeout SHALL hold until the next RESP.
REQ-028 A new grant SHALL be possible the cycle after RESP; busy SHALL be low in IDLE only.
REQ-029 Bit counters SHALL be wide enough for SF_BITS without wrap; prescale counter 8 bits.

Reset
REQ-030 On rst_n low, immediately: state IDLE, debug_rx_clk=1, debug_rx_data=0, readies/rsp_valids=0, rsp_frame=0, rsp_timeout=0, busy=0, synchronizers to 1 (clk) / 0 (data), round-robin pointer so req0 wins next.
REQ-031 Reset mid-frame SHALL abandon the frame with no response pulse.

Verification (BITS=16, SF_BITS=32)
REQ-032 req0 frame 0xA5A50001, prescaler=2, debug_tx looped from debug_rx -> req0_ready one pulse, 32 low/high pairs of 2 cycles each, rsp0_valid pulse, rsp_frame=0xA5A50001, rsp_timeout=0.
REQ-033 req0 and req1 valid same cycle, repeated 3 frames -> grant order 0,1,0; rsp pulses on matching index only.
REQ-034 debug_tx_clk held high, TIMEOUT=100 -> rsp0_valid about 100 cycles after TX completion, rsp_timeout=1, rsp_frame=0.
REQ-035 prescaler=0 -> each phase 1 cycle, 64 cycles of transmission, same as prescaler=1.
REQ-036 rst_n low during bit 10 of TX -> debug_rx_clk=1 asynchronously, no rsp pulse, next request accepted normally.
REQ-037 req1 raised while busy -> req1_ready stays 0 until the cycle after RESP, then pulses.

Source files
------------

// File: rtl/serial_debug_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_debug_arbiter_if
// Description : Requester handshake, response and debug-ring signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_debug_arbiter_if #(
  parameter int BITS = 128
);
  localparam int SF_BITS = BITS + 16;

  logic [7:0]         prescaler;
  logic               req0_valid;
  logic               req1_valid;
  logic [SF_BITS-1:0] req0_frame;
  logic [SF_BITS-1:0] req1_frame;
  logic               req0_ready;
  logic               req1_ready;
  logic               rsp0_valid;
  logic               rsp1_valid;
  logic [SF_BITS-1:0] rsp_frame;
  logic               rsp_timeout;
  logic               busy;
  logic               debug_rx_data;
  logic               debug_rx_clk;
  logic               debug_tx_data;
  logic               debug_tx_clk;

  modport master (
    output prescaler, req0_valid, req1_valid, req0_frame, req1_frame,
    output debug_tx_data, debug_tx_clk,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_frame,
    input  rsp_timeout, busy, debug_rx_data, debug_rx_clk
  );

  modport slave (
    input  prescaler, req0_valid, req1_valid, req0_frame, req1_frame,
    input  debug_tx_data, debug_tx_clk,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_frame,
    output rsp_timeout, busy, debug_rx_data, debug_rx_clk
  );
endinterface
`default_nettype wire

// File: rtl/serial_debug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : serial_debug_arbiter
// Description : Round-robin arbiter for two requesters sharing a serial debug
//               ring; shifts a frame out MSB first and collects the reply.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_debug_arbiter #(
  parameter int BITS    = 128,
  parameter int TIMEOUT = 65535
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  serial_debug_arbiter_if.slave bus
);
  localparam int SF_BITS = BITS + 16;
  localparam int CW      = $clog2(SF_BITS + 1);
  localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] SF_CNT  = CW'(SF_BITS);
  localparam logic [CW-1:0] SF_LAST = CW'(SF_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_LOW  = 3'd1,
    TX_HIGH = 3'd2,
    RX_WAIT = 3'd3,
    RESP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SF_BITS-1:0] shift_q, shift_d;
  logic [SF_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [SF_BITS-1:0] rsp_frame_q, rsp_frame_d;
  logic [CW-1:0]      bit_q, bit_d;
  logic [CW-1:0]      rx_cnt_q, rx_cnt_d;
  logic [TW-1:0]      to_q, to_d;
  logic [7:0]         presc_q, presc_d;
  logic               grant_q, grant_d;
  logic               last_q, last_d;
  logic               rsp_to_q, rsp_to_d;
  logic               rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic               rx_clk_q, rx_clk_d, rx_dat_q, rx_dat_d;
  logic               busy_q, busy_d;
  logic               tx_clk_s1_q, tx_clk_s2_q, tx_clk_prev_q;
  logic               tx_dat_s1_q, tx_dat_s2_q;

  logic [7:0] w_presc_eff;
  logic       w_phase_done, w_rise, w_armed, w_pick1, w_accept;
  logic       w_rx_done, w_to_hit;

  assign w_presc_eff  = (bus.prescaler == 8'd0) ? 8'd1 : bus.prescaler;
  assign w_phase_done = (presc_q >= w_presc_eff - 8'd1);
  assign w_rise       = tx_clk_s2_q & ~tx_clk_prev_q;
  assign w_armed      = (state_q == TX_LOW) || (state_q == TX_HIGH) || (state_q == RX_WAIT);
  // last_q holds the previous grant; on a tie the other requester wins.
  assign w_pick1      = bus.req1_valid & (~bus.req0_valid | ~last_q);
  assign w_accept     = (state_q == IDLE) & (bus.req0_valid | bus.req1_valid);

  assign bus.req0_ready    = rst_n & w_accept & ~w_pick1;
  assign bus.req1_ready    = rst_n & w_accept & w_pick1;
  assign bus.rsp0_valid    = rsp0_q;
  assign bus.rsp1_valid    = rsp1_q;
  assign bus.rsp_frame     = rsp_frame_q;
  assign bus.rsp_timeout   = rsp_to_q;
  assign bus.busy          = busy_q;
  assign bus.debug_rx_clk  = rx_clk_q;
  assign bus.debug_rx_data = rx_dat_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    grant_d     = grant_q;
    last_d      = last_q;
    presc_d     = presc_q;
    bit_d       = bit_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    to_d        = to_q;
    rsp_frame_d = rsp_frame_q;
    rsp_to_d    = rsp_to_q;
    rsp0_d      = 1'b0;
    rsp1_d      = 1'b0;
    w_to_hit    = 1'b0;

    if (w_accept) begin
      rx_cnt_d   = '0;
      rx_shift_d = '0;
      to_d       = '0;
    end else if (w_armed) begin
      if (w_rise) begin
        to_d = '0;
        if (rx_cnt_q != SF_CNT) begin
          rx_shift_d = {rx_shift_q[SF_BITS-2:0], tx_dat_s2_q};
          rx_cnt_d   = rx_cnt_q + CW'(1);
        end
      end else if (to_q != '1) begin
        to_d = to_q + TW'(1);
      end
    end
    w_rx_done = (rx_cnt_d == SF_CNT);

    case (state_q)
      IDLE: begin
        if (w_accept) begin
          grant_d = w_pick1;
          last_d  = w_pick1;
          shift_d = w_pick1 ? bus.req1_frame : bus.req0_frame;
          presc_d = '0;
          bit_d   = '0;
          state_d = TX_LOW;
        end
      end
      TX_LOW: begin
        if (w_phase_done) begin
          presc_d = '0;
          state_d = TX_HIGH;
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      TX_HIGH: begin
        if (w_phase_done) begin
          presc_d = '0;
          shift_d = {shift_q[SF_BITS-2:0], 1'b0};
          bit_d   = bit_q + CW'(1);
          if (bit_q == SF_LAST) begin
            // Abort window measures silence after the last bit leaves.
            to_d    = '0;
            state_d = w_rx_done ? RESP : RX_WAIT;
          end else begin
            state_d = TX_LOW;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      RX_WAIT: begin
        if (w_rx_done) begin
          state_d = RESP;
        end else if (!w_rise && (to_q >= TO_LAST)) begin
          w_to_hit = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) begin
      rsp_frame_d = rx_shift_d;
      rsp_to_d    = w_to_hit;
      rsp0_d      = ~grant_q;
      rsp1_d      = grant_q;
    end

    rx_clk_d = (state_d != TX_LOW);
    rx_dat_d = ((state_d == TX_LOW) || (state_d == TX_HIGH)) ? shift_d[SF_BITS-1] : 1'b0;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      rx_shift_q    <= '0;
      rsp_frame_q   <= '0;
      bit_q         <= '0;
      rx_cnt_q      <= '0;
      to_q          <= '0;
      presc_q       <= '0;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      rsp_to_q      <= 1'b0;
      rsp0_q        <= 1'b0;
      rsp1_q        <= 1'b0;
      rx_clk_q      <= 1'b1;
      rx_dat_q      <= 1'b0;
      busy_q        <= 1'b0;
      tx_clk_s1_q   <= 1'b1;
      tx_clk_s2_q   <= 1'b1;
      tx_clk_prev_q <= 1'b1;
      tx_dat_s1_q   <= 1'b0;
      tx_dat_s2_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      rx_shift_q    <= rx_shift_d;
      rsp_frame_q   <= rsp_frame_d;
      bit_q         <= bit_d;
      rx_cnt_q      <= rx_cnt_d;
      to_q          <= to_d;
      presc_q       <= presc_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      rsp_to_q      <= rsp_to_d;
      rsp0_q        <= rsp0_d;
      rsp1_q        <= rsp1_d;
      rx_clk_q      <= rx_clk_d;
      rx_dat_q      <= rx_dat_d;
      busy_q        <= busy_d;
      tx_clk_s1_q   <= bus.debug_tx_clk;
      tx_clk_s2_q   <= tx_clk_s1_q;
      tx_clk_prev_q <= tx_clk_s2_q;
      tx_dat_s1_q   <= bus.debug_tx_data;
      tx_dat_s2_q   <= tx_dat_s1_q;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_serial_debug_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_debug_arbiter
// Description : Self-checking bench: vector table, scoreboard, corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_debug_arbiter;
  logic clk;
  logic rst_n;
  bit   loop_en;
  int   checks;
  int   failures;

  typedef struct packed {
    logic        idx;
    logic [31:0] frame;
    logic        to;
  } rsp_t;

  typedef struct {
    bit          sel;
    logic [31:0] frame;
    logic [7:0]  presc;
    int          exp_lows;
    int          exp_period;
  } vec_t;

  rsp_t sb_rsp[$];
  logic sb_grant[$];
  vec_t vecs[5];

  serial_debug_arbiter_if #(.BITS(16)) bus ();

  serial_debug_arbiter #(.BITS(16), .TIMEOUT(100)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Loopback ring: the single debug node simply echoes what it receives.
  assign bus.debug_tx_clk  = loop_en ? bus.debug_rx_clk  : 1'b1;
  assign bus.debug_tx_data = loop_en ? bus.debug_rx_data : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_ready || bus.req1_ready) begin
        check("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 0);
        check("ready_in_idle", 64'(bus.busy), 0);
        if (sb_grant.size() == 0) begin
          checks++; failures++;
          $display("FAIL grant_order: unexpected ready req1=%0b", bus.req1_ready);
        end else begin
          check("grant_order", 64'(bus.req1_ready), 64'(sb_grant.pop_front()));
        end
      end
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        check("rsp_onehot", 64'(bus.rsp0_valid & bus.rsp1_valid), 0);
        if (sb_rsp.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_unexpected: rsp1_valid=%0b frame=%0h", bus.rsp1_valid, bus.rsp_frame);
        end else begin
          rsp_t e;
          e = sb_rsp.pop_front();
          check("rsp_idx", 64'(bus.rsp1_valid), 64'(e.idx));
          check("rsp_frame", 64'(bus.rsp_frame), 64'(e.frame));
          check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.to));
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [31:0] frame);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (sel) begin bus.req1_frame = frame; bus.req1_valid = 1'b1; end
    else     begin bus.req0_frame = frame; bus.req0_valid = 1'b1; end
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = sel ? bus.req1_ready : bus.req0_ready;
    end
    check($sformatf("req%0d_accept", sel), 64'(got), 1);
    @(posedge clk); #1;
    if (sel) bus.req1_valid = 1'b0;
    else     bus.req0_valid = 1'b0;
  endtask

  task automatic measure(output int falls, output int lows, output int mn,
                         output int mx, output int gap, output bit done);
    int since, cyc, last_rise;
    bit prev;
    falls = 0; lows = 0; mn = 1 << 30; mx = 0; gap = -1; done = 1'b0;
    since = 0; cyc = 0; last_rise = 0; prev = 1'b1;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        done = 1'b1;
        gap  = cyc - last_rise;
      end else begin
        since++;
        if (!bus.debug_rx_clk) lows++;
        if (prev && !bus.debug_rx_clk) begin
          if (falls > 0) begin
            if (since < mn) mn = since;
            if (since > mx) mx = since;
          end
          since = 0;
          falls++;
        end
        if (!prev && bus.debug_rx_clk) last_rise = cyc;
        prev = bus.debug_rx_clk;
      end
    end
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = (sb_rsp.size() == 0) && (sb_grant.size() == 0) && !bus.busy;
    end
    check(name, 64'(ok), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  falls, lows, mn, mx, gap, npulse;
    bit  done, prev, hit, got;
    int  since_rsp;

    checks = 0; failures = 0;
    vecs[0] = '{sel: 1'b0, frame: 32'hA5A5_0001, presc: 8'd2, exp_lows: 64, exp_period: 4};
    vecs[1] = '{sel: 1'b1, frame: 32'h1234_5678, presc: 8'd1, exp_lows: 32, exp_period: 2};
    vecs[2] = '{sel: 1'b0, frame: 32'hFFFF_FFFF, presc: 8'd0, exp_lows: 32, exp_period: 2};
    vecs[3] = '{sel: 1'b1, frame: 32'h0000_0000, presc: 8'd3, exp_lows: 96, exp_period: 6};
    vecs[4] = '{sel: 1'b0, frame: 32'h8000_0001, presc: 8'd1, exp_lows: 32, exp_period: 2};

    rst_n = 1'b0; loop_en = 1'b1;
    bus.prescaler = 8'd2;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_frame = '0;   bus.req1_frame = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rx_clk", 64'(bus.debug_rx_clk), 1);
    check("rst_rx_data", 64'(bus.debug_rx_data), 0);
    check("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 0);
    check("rst_rsp_valid", 64'({bus.rsp0_valid, bus.rsp1_valid}), 0);
    check("rst_rsp_frame", 64'(bus.rsp_frame), 0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 0);
    check("rst_busy", 64'(bus.busy), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Tie on every arbitration round: expected grant order 0,1,0.
    bus.prescaler = 8'd1;
    sb_grant.push_back(1'b0); sb_grant.push_back(1'b1); sb_grant.push_back(1'b0);
    sb_rsp.push_back('{1'b0, 32'h1111_AAAA, 1'b0});
    sb_rsp.push_back('{1'b1, 32'h2222_BBBB, 1'b0});
    sb_rsp.push_back('{1'b0, 32'h3333_CCCC, 1'b0});
    fork
      begin send(1'b0, 32'h1111_AAAA); send(1'b0, 32'h3333_CCCC); end
      begin send(1'b1, 32'h2222_BBBB); end
    join
    drain("tie_drain");

    // Silent ring: no return edges, abort after the timeout window.
    loop_en = 1'b0;
    bus.prescaler = 8'd2;
    sb_grant.push_back(1'b0);
    sb_rsp.push_back('{1'b0, 32'h0, 1'b1});
    send(1'b0, 32'h5A5A_5A5A);
    measure(falls, lows, mn, mx, gap, done);
    check("to_done", 64'(done), 1);
    check("to_falls", 64'(falls), 32);
    check("to_gap_in_window", 64'((gap >= 100) && (gap <= 110)), 1);
    if (!((gap >= 100) && (gap <= 110))) $display("  timeout gap was %0d cycles", gap);
    drain("to_drain");
    loop_en = 1'b1;

    for (int v = 0; v < 5; v++) begin
      bus.prescaler = vecs[v].presc;
      sb_grant.push_back(vecs[v].sel);
      sb_rsp.push_back('{vecs[v].sel, vecs[v].frame, 1'b0});
      send(vecs[v].sel, vecs[v].frame);
      measure(falls, lows, mn, mx, gap, done);
      check($sformatf("vec%0d_done", v), 64'(done), 1);
      check($sformatf("vec%0d_falls", v), 64'(falls), 32);
      check($sformatf("vec%0d_lows", v), 64'(lows), 64'(vecs[v].exp_lows));
      check($sformatf("vec%0d_period_min", v), 64'(mn), 64'(vecs[v].exp_period));
      check($sformatf("vec%0d_period_max", v), 64'(mx), 64'(vecs[v].exp_period));
      check($sformatf("vec%0d_rx_clk_idle", v), 64'(bus.debug_rx_clk), 1);
      drain($sformatf("vec%0d_drain", v));
    end

    // Reset in the middle of bit 10.
    bus.prescaler = 8'd2;
    sb_grant.push_back(1'b0);
    send(1'b0, 32'h0F0F_1234);
    falls = 0; prev = 1'b1; hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (prev && !bus.debug_rx_clk) falls++;
      prev = bus.debug_rx_clk;
      if (falls == 10) hit = 1'b1;
    end
    check("reach_bit10", 64'(hit), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rx_clk", 64'(bus.debug_rx_clk), 1);
    check("async_busy", 64'(bus.busy), 0);
    check("async_rsp_frame", 64'(bus.rsp_frame), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid) npulse++;
    end
    check("no_rsp_after_reset", 64'(npulse), 0);

    // First tie after reset goes to req0 even though req0 was granted last.
    bus.prescaler = 8'd1;
    sb_grant.push_back(1'b0); sb_grant.push_back(1'b1);
    sb_rsp.push_back('{1'b0, 32'hC3C3_0F0F, 1'b0});
    sb_rsp.push_back('{1'b1, 32'h7E81_4224, 1'b0});
    fork
      send(1'b0, 32'hC3C3_0F0F);
      send(1'b1, 32'h7E81_4224);
    join
    drain("post_reset_drain");

    // req1 raised while busy must wait until the cycle after RESP.
    sb_grant.push_back(1'b0); sb_grant.push_back(1'b1);
    sb_rsp.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
    sb_rsp.push_back('{1'b1, 32'h0BAD_F00D, 1'b0});
    send(1'b0, 32'hDEAD_BEEF);
    repeat (5) @(posedge clk);
    #1;
    bus.req1_frame = 32'h0BAD_F00D;
    bus.req1_valid = 1'b1;
    got = 1'b0; since_rsp = -1;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (since_rsp >= 0) since_rsp++;
      if (bus.rsp0_valid) since_rsp = 0;
      if (bus.req1_ready) got = 1'b1;
    end
    check("busy_req1_accept", 64'(got), 1);
    check("busy_req1_after_resp", 64'(since_rsp), 1);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    drain("busy_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
